// File: rtl/hazard_tracker_pkg.sv
// rtl/hazard_tracker_pkg.sv - shared stage-entry types, NOP constant and hazard state encodings
package hazard_tracker_pkg;

    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
        logic                 memaccess;
    } stage_t;

    localparam int     ENTRY_W   = $bits(stage_t);
    localparam stage_t NOP_ENTRY = '0;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MEM_WAIT   = 2'd2,
        HZ_FLUSH      = 2'd3
    } hz_state_t;

    // A source only depends on an in-flight load when it names a real (nonzero) register.
    function automatic logic src_hit(input logic [REG_IDX_W-1:0] rs, input stage_t e);
        return (rs != '0) && e.memread && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one pipeline metadata register; hold wins over clear
module hazard_stage_reg
    import hazard_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_hold,
    input  logic               i_clear,
    input  logic [ENTRY_W-1:0] i_d,
    output logic [ENTRY_W-1:0] o_q
);

    logic [ENTRY_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= NOP_ENTRY;
        end else if (!i_hold) begin
            r_q <= i_clear ? NOP_ENTRY : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - destination metadata pipeline with stall/bubble/flush/freeze decisions
module hazard_tracker
    import hazard_tracker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memaccess,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic [4:0]  ID_EX_rd,
    output logic [4:0]  EX_MEM_rd,
    output logic [4:0]  MEM_WB_rd,
    output logic        EX_MEM_CTRL_regwrite,
    output logic        MEM_WB_CTRL_regwrite,
    output logic        stall,
    output logic        bubble,
    output logic        flush_ifid,
    output logic        freeze,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_count
);

    stage_t    w_id_entry;
    stage_t    w_idex;
    stage_t    w_exmem;
    stage_t    w_memwb;
    logic      w_freeze;
    logic      w_branch;
    logic      w_load_use;
    logic      w_unused_memwb;
    hz_state_t w_next_state;
    hz_state_t r_hz_state;
    logic [15:0] r_stall_count;

    assign w_id_entry = '{rd: id_rd, regwrite: id_regwrite, memread: id_memread, memaccess: id_memaccess};

    // Gating with rst_n keeps every decision at 0 while reset is held.
    assign w_freeze   = rst_n & w_exmem.memaccess & ~mem_ready;
    assign w_branch   = rst_n & branch_taken;
    assign w_load_use = rst_n & id_valid &
                        (src_hit(id_rs1, w_idex) | src_hit(id_rs1, w_exmem) |
                         src_hit(id_rs2, w_idex) | src_hit(id_rs2, w_exmem));

    assign freeze     = w_freeze;
    assign flush_ifid = ~w_freeze & w_branch;
    assign bubble     = ~w_freeze & (w_branch | w_load_use);
    assign stall      = w_freeze | (~w_branch & w_load_use);

    hazard_stage_reg u_id_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (w_freeze),
        .i_clear (w_branch | w_load_use | ~id_valid),
        .i_d     (w_id_entry),
        .o_q     (w_idex)
    );

    hazard_stage_reg u_ex_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (w_freeze),
        .i_clear (1'b0),
        .i_d     (w_idex),
        .o_q     (w_exmem)
    );

    // While frozen the access has not finished, so nothing retires into MEM/WB.
    hazard_stage_reg u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (1'b0),
        .i_clear (w_freeze),
        .i_d     (w_exmem),
        .o_q     (w_memwb)
    );

    assign w_unused_memwb = w_memwb.memread | w_memwb.memaccess;

    always_comb begin
        w_next_state = HZ_RUN;
        if (w_freeze) begin
            w_next_state = HZ_MEM_WAIT;
        end else if (w_branch) begin
            w_next_state = HZ_FLUSH;
        end else if (w_load_use) begin
            w_next_state = HZ_LOAD_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hz_state    <= HZ_RUN;
            r_stall_count <= '0;
        end else begin
            r_hz_state <= w_next_state;
            if (stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign ID_EX_rd             = w_idex.rd;
    assign EX_MEM_rd            = w_exmem.rd;
    assign MEM_WB_rd            = w_memwb.rd;
    assign EX_MEM_CTRL_regwrite = w_exmem.regwrite;
    assign MEM_WB_CTRL_regwrite = w_memwb.regwrite;
    assign hz_state             = r_hz_state;
    assign stall_count          = r_stall_count;

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - randomized and directed self-checking bench for hazard_tracker
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, id_memaccess = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b1;
    logic [4:0]  ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
    logic        EX_MEM_CTRL_regwrite, MEM_WB_CTRL_regwrite;
    logic        stall, bubble, flush_ifid, freeze;
    logic [1:0]  hz_state;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;

    hazard_tracker dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .id_valid             (id_valid),
        .id_rs1               (id_rs1),
        .id_rs2               (id_rs2),
        .id_rd                (id_rd),
        .id_regwrite          (id_regwrite),
        .id_memread           (id_memread),
        .id_memaccess         (id_memaccess),
        .branch_taken         (branch_taken),
        .mem_ready            (mem_ready),
        .ID_EX_rd             (ID_EX_rd),
        .EX_MEM_rd            (EX_MEM_rd),
        .MEM_WB_rd            (MEM_WB_rd),
        .EX_MEM_CTRL_regwrite (EX_MEM_CTRL_regwrite),
        .MEM_WB_CTRL_regwrite (MEM_WB_CTRL_regwrite),
        .stall                (stall),
        .bubble               (bubble),
        .flush_ifid           (flush_ifid),
        .freeze               (freeze),
        .hz_state             (hz_state),
        .stall_count          (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pipeline: index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
    logic [4:0] m_rd[3] = '{5'd0, 5'd0, 5'd0};
    bit         m_rw[3] = '{0, 0, 0};
    bit         m_mr[3] = '{0, 0, 0};
    bit         m_ma[3] = '{0, 0, 0};
    int         m_state = 0;
    int         m_cnt = 0;

    function automatic bit m_hit(input logic [4:0] rs);
        return (rs != 0) && ((m_mr[0] && m_rd[0] == rs) || (m_mr[1] && m_rd[1] == rs));
    endfunction
    function automatic bit m_frz();
        return (rst_n === 1'b1) && m_ma[1] && !mem_ready;
    endfunction
    function automatic bit m_br();
        return (rst_n === 1'b1) && branch_taken;
    endfunction
    function automatic bit m_lu();
        return (rst_n === 1'b1) && id_valid && (m_hit(id_rs1) || m_hit(id_rs2));
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    m_rd[i] = 0; m_rw[i] = 0; m_mr[i] = 0; m_ma[i] = 0;
                end
                m_state = 0;
                m_cnt = 0;
            end else begin
                bit f, b, l;
                f = m_frz(); b = m_br(); l = m_lu();
                if (f) begin
                    m_rd[2] = 0; m_rw[2] = 0; m_mr[2] = 0; m_ma[2] = 0;
                    m_state = 2;
                end else begin
                    for (int i = 2; i > 0; i--) begin
                        m_rd[i] = m_rd[i-1]; m_rw[i] = m_rw[i-1];
                        m_mr[i] = m_mr[i-1]; m_ma[i] = m_ma[i-1];
                    end
                    if (b || l || !id_valid) begin
                        m_rd[0] = 0; m_rw[0] = 0; m_mr[0] = 0; m_ma[0] = 0;
                    end else begin
                        m_rd[0] = id_rd; m_rw[0] = id_regwrite;
                        m_mr[0] = id_memread; m_ma[0] = id_memaccess;
                    end
                    m_state = b ? 3 : (l ? 1 : 0);
                end
                if ((f || (!b && l)) && m_cnt < 65535) m_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("ID_EX_rd", 32'(ID_EX_rd), 32'(m_rd[0]));
            chk("EX_MEM_rd", 32'(EX_MEM_rd), 32'(m_rd[1]));
            chk("MEM_WB_rd", 32'(MEM_WB_rd), 32'(m_rd[2]));
            chk("EX_MEM_regwrite", 32'(EX_MEM_CTRL_regwrite), 32'(m_rw[1]));
            chk("MEM_WB_regwrite", 32'(MEM_WB_CTRL_regwrite), 32'(m_rw[2]));
            chk("freeze", 32'(freeze), 32'(m_frz()));
            chk("flush_ifid", 32'(flush_ifid), 32'(!m_frz() && m_br()));
            chk("bubble", 32'(bubble), 32'(!m_frz() && (m_br() || m_lu())));
            chk("stall", 32'(stall), 32'(m_frz() || (!m_br() && m_lu())));
            chk("hz_state", 32'(hz_state), m_state);
            chk("stall_count", 32'(stall_count), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input bit rw, input bit mr, input bit ma);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; id_memaccess = ma;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("reset_id_ex_rd", 32'(ID_EX_rd), 0);
        chk("reset_hz_state", 32'(hz_state), 0);
        chk("reset_stall_count", 32'(stall_count), 0);

        // ALU chain forwards without stalling
        set_id(1, 0, 0, 5, 1, 0, 0);
        tick();
        set_id(1, 5, 0, 6, 1, 0, 0);
        #1;
        chk("alu_no_stall", 32'(stall), 0);
        chk("alu_id_ex_rd", 32'(ID_EX_rd), 5);
        tick();
        idle();
        #1;
        chk("alu_ex_mem_rd", 32'(EX_MEM_rd), 5);
        chk("alu_ex_mem_rw", 32'(EX_MEM_CTRL_regwrite), 1);

        // load-use: two bubbles
        do_reset();
        set_id(1, 0, 0, 7, 1, 1, 1);
        tick();
        set_id(1, 0, 7, 9, 1, 0, 0);
        #1;
        chk("lu_stall_1", 32'(stall), 1);
        chk("lu_bubble_1", 32'(bubble), 1);
        tick();
        #1;
        chk("lu_stall_2", 32'(stall), 1);
        chk("lu_bubble_2", 32'(bubble), 1);
        chk("lu_hz_state", 32'(hz_state), 1);
        tick();
        #1;
        chk("lu_stall_3", 32'(stall), 0);
        chk("lu_stall_count", 32'(stall_count), 2);
        tick();
        idle();
        #1;
        chk("lu_consumer_id_ex", 32'(ID_EX_rd), 9);

        // load to x0 never stalls
        set_id(1, 0, 0, 0, 1, 1, 1);
        tick();
        set_id(1, 0, 0, 3, 1, 0, 0);
        #1;
        chk("x0_no_stall", 32'(stall), 0);
        tick();
        idle();

        // branch overrides load-use
        set_id(1, 0, 0, 7, 1, 1, 1);
        tick();
        set_id(1, 7, 0, 8, 1, 0, 0);
        branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(flush_ifid), 1);
        chk("br_bubble", 32'(bubble), 1);
        chk("br_stall", 32'(stall), 0);
        tick();
        branch_taken = 1'b0;
        idle();
        #1;
        chk("br_hz_state", 32'(hz_state), 3);
        chk("br_id_ex_rd", 32'(ID_EX_rd), 0);

        // memory wait on a store
        do_reset();
        set_id(1, 0, 0, 4, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 3, 0, 0, 1);
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("mw_freeze_0", 32'(freeze), 1);
        chk("mw_stall_0", 32'(stall), 1);
        tick();
        #1;
        chk("mw_ex_mem_rd_held", 32'(EX_MEM_rd), 3);
        chk("mw_mem_wb_rw", 32'(MEM_WB_CTRL_regwrite), 0);
        chk("mw_freeze_1", 32'(freeze), 1);
        tick();
        tick();
        mem_ready = 1'b1;
        #1;
        chk("mw_release", 32'(freeze), 0);
        chk("mw_stall_count", 32'(stall_count), 3);
        chk("mw_hz_state", 32'(hz_state), 2);
        tick();

        // reset in the middle of a freeze
        set_id(1, 0, 0, 3, 0, 0, 1);
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("rf_freeze_before", 32'(freeze), 1);
        rst_n = 1'b0;
        #1;
        chk("rf_freeze", 32'(freeze), 0);
        chk("rf_stall", 32'(stall), 0);
        chk("rf_ex_mem_rd", 32'(EX_MEM_rd), 0);
        chk("rf_hz_state", 32'(hz_state), 0);
        chk("rf_stall_count", 32'(stall_count), 0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;

        // randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            tick();
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            if (id_memread) id_memaccess = 1'b1;
            branch_taken = ($urandom_range(0, 9) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        idle();
        branch_taken = 1'b0;
        mem_ready = 1'b1;

        // counter saturation
        do_reset();
        set_id(1, 0, 0, 2, 0, 0, 1);
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        repeat (70000) tick();
        #1;
        chk("sat_stall_count", 32'(stall_count), 32'hFFFF);
        mem_ready = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
